// File: rtl/response_timeout_controller_if.sv
// Handshake and status bundle between a requester and response_timeout_controller.
interface response_timeout_controller_if #(
  parameter int unsigned BIT_WIDTH   = 16,
  parameter int unsigned RETRY_WIDTH = 4
);
  logic                   start_valid;
  logic                   start_ready;
  logic [BIT_WIDTH-1:0]   timeout_cycles;
  logic [RETRY_WIDTH-1:0] max_retries;
  logic                   response_valid;
  logic                   abort;
  logic                   timer_expired;
  logic                   timer_enable;
  logic                   timer_load;
  logic [BIT_WIDTH-1:0]   timer_count;
  logic                   retry;
  logic                   done;
  logic [1:0]             done_status;
  logic [RETRY_WIDTH-1:0] retries_used;
  logic                   busy;
  logic                   stats_clear;
  logic [15:0]            timeout_events;

  modport master (
    output start_valid, timeout_cycles, max_retries, response_valid, abort,
           timer_expired, stats_clear,
    input  start_ready, timer_enable, timer_load, timer_count, retry, done,
           done_status, retries_used, busy, timeout_events
  );

  modport slave (
    input  start_valid, timeout_cycles, max_retries, response_valid, abort,
           timer_expired, stats_clear,
    output start_ready, timer_enable, timer_load, timer_count, retry, done,
           done_status, retries_used, busy, timeout_events
  );
endinterface

// File: rtl/response_timeout_controller.sv
// Timed request controller: loads a downstream cycle timer, retries on expiry, reports status.
// Optional expiry statistics counter enabled by RESPONSE_TIMEOUT_CONTROLLER_STATS_EN.
module response_timeout_controller #(
  parameter int unsigned BIT_WIDTH   = 16,
  parameter int unsigned RETRY_WIDTH = 4
) (
  input logic                          clock,
  input logic                          reset_n,
  response_timeout_controller_if.slave bus
);

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
  localparam logic [1:0] STATUS_ABORT   = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    RETRY = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [1:0]             next_status;
  logic                   accept;

  logic                   start_ready_r;
  logic                   timer_enable_r;
  logic                   timer_load_r;
  logic                   retry_r;
  logic                   done_r;
  logic [1:0]             done_status_r;
  logic                   busy_r;
  logic [BIT_WIDTH-1:0]   timeout_r;
  logic [RETRY_WIDTH-1:0] max_retries_r;
  logic [RETRY_WIDTH-1:0] retries_used_r;

  assign accept = (state == IDLE) && bus.start_valid;

  // Next state; abort outranks response, which outranks expiry.
  always_comb begin
    next_state  = state;
    next_status = STATUS_OK;
    case (state)
      IDLE: begin
        if (bus.start_valid) next_state = LOAD;
      end
      LOAD: begin
        if (bus.abort) begin
          next_state  = DONE;
          next_status = STATUS_ABORT;
        end else begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (bus.abort) begin
          next_state  = DONE;
          next_status = STATUS_ABORT;
        end else if (bus.response_valid) begin
          next_state  = DONE;
          next_status = STATUS_OK;
        end else if (bus.timer_expired) begin
          if (retries_used_r < max_retries_r) begin
            next_state = RETRY;
          end else begin
            next_state  = DONE;
            next_status = STATUS_TIMEOUT;
          end
        end
      end
      RETRY: begin
        if (bus.abort) begin
          next_state  = DONE;
          next_status = STATUS_ABORT;
        end else begin
          next_state = LOAD;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State and outputs registered together so outputs line up with the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      start_ready_r  <= 1'b1;
      timer_enable_r <= 1'b0;
      timer_load_r   <= 1'b0;
      retry_r        <= 1'b0;
      done_r         <= 1'b0;
      done_status_r  <= 2'b00;
      busy_r         <= 1'b0;
      timeout_r      <= '0;
      max_retries_r  <= '0;
      retries_used_r <= '0;
    end else begin
      state          <= next_state;
      start_ready_r  <= (next_state == IDLE);
      timer_enable_r <= (next_state == LOAD) || (next_state == WAIT);
      timer_load_r   <= (next_state == LOAD);
      retry_r        <= (next_state == RETRY);
      done_r         <= (next_state == DONE);
      done_status_r  <= (next_state == DONE) ? next_status : 2'b00;
      busy_r         <= (next_state != IDLE);
      if (accept) begin
        timeout_r      <= bus.timeout_cycles;
        max_retries_r  <= bus.max_retries;
        retries_used_r <= '0;
      end else if (next_state == RETRY) begin
        retries_used_r <= retries_used_r + RETRY_WIDTH'(1);
      end
    end
  end

  assign bus.start_ready  = start_ready_r;
  assign bus.timer_enable = timer_enable_r;
  assign bus.timer_load   = timer_load_r;
  assign bus.timer_count  = timeout_r;
  assign bus.retry        = retry_r;
  assign bus.done         = done_r;
  assign bus.done_status  = done_status_r;
  assign bus.retries_used = retries_used_r;
  assign bus.busy         = busy_r;

`ifdef RESPONSE_TIMEOUT_CONTROLLER_STATS_EN
  logic [15:0] event_count;
  logic        count_event;

  assign count_event = (state == WAIT) && bus.timer_expired && !bus.abort && !bus.response_valid;

  // Saturating expiry counter; clear wins over increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      event_count <= 16'd0;
    end else if (bus.stats_clear) begin
      event_count <= 16'd0;
    end else if (count_event && (event_count != 16'hFFFF)) begin
      event_count <= event_count + 16'd1;
    end
  end

  assign bus.timeout_events = event_count;
`else
  logic unused_stats_clear;
  assign unused_stats_clear  = bus.stats_clear;
  assign bus.timeout_events  = 16'd0;
`endif

endmodule

// File: doc/response_timeout_controller.md
RESPONSE_TIMEOUT_CONTROLLER -- requirements
Module: response_timeout_controller

Interface
REQ-001 Parameter BIT_WIDTH, default 16, width of the timeout cycle count and of timer_count.
REQ-002 Parameter RETRY_WIDTH, default 4, width of max_retries and retries_used.
REQ-003 The block SHALL have these ports; clock and reset_n are decided: reset_n, asynchronous, active-low; clock clock.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request to begin a timed transaction.
- start_ready  out  1  high only in IDLE.
- timeout_cycles  in  BIT_WIDTH  timeout value, latched on start accept.
- max_retries  in  RETRY_WIDTH  retry budget, latched on start accept.
- response_valid  in  1  response arrived; sampled only in WAIT.
- abort  in  1  cancel the current transaction.
- timer_expired  in  1  expired from the downstream cycle timer.
- timer_enable  out  1  cycle timer enable.
- timer_load  out  1  cycle timer load_count.
- timer_count  out  BIT_WIDTH  cycle timer count; equals the latched timeout_cycles.
- retry  out  1  one-cycle pulse per retransmit request.
- done  out  1  one-cycle completion pulse.
- done_status  out  2  status: 00 ok, 01 timeout, 10 aborted; valid with done.
- retries_used  out  RETRY_WIDTH  retries consumed in the current or last transaction.
- busy  out  1  high in any state except IDLE.
- stats_clear  in  1  clears timeout_events.
- timeout_events  out  16  saturating count of timer expiries seen in WAIT.

Function
REQ-004 The FSM SHALL have the states IDLE, LOAD, WAIT, RETRY and DONE, each a registered state.
REQ-005 IDLE: start_ready=1; start_valid=1 latches timeout_cycles and max_retries, clears retries_used, and goes to LOAD.
REQ-006 LOAD: timer_enable=1 and timer_load=1 for exactly one cycle, then go to WAIT.
REQ-007 WAIT: timer_enable=1 and timer_load=0.
- response_valid=1 -> DONE with status 00.
- else timer_expired=1 and retries_used<max_retries -> RETRY.
- else timer_expired=1 -> DONE with status 01.
REQ-008 response_valid and timer_expired high in the same WAIT cycle SHALL resolve as ok (response wins).
REQ-009 RETRY: retry=1 for one cycle, retries_used increments, then go to LOAD.
REQ-010 DONE: done=1 with done_status driven for one cycle, then go to IDLE; timer_enable=0.
REQ-011 timer_expired SHALL be ignored in every state except WAIT (the timer reads expired after reset and during the load cycle).
REQ-012 abort=1 in LOAD, WAIT or RETRY SHALL go to DONE with status 10; abort is ignored in IDLE and DONE.
REQ-013 abort has priority over response_valid and timer_expired.
REQ-014 timeout_cycles=0 SHALL produce an expiry on the first WAIT cycle.
REQ-015 Latency: accept at cycle T -> LOAD at T+1, WAIT from T+2, first expiry seen at T+2+N (N = timeout_cycles), DONE no earlier than T+3+N.
REQ-016 retries_used SHALL hold its value after DONE until the next start is accepted.
REQ-017 max_retries=0 SHALL mean a single attempt with no retry pulse.
REQ-018 response_valid and start_valid outside their accepting states SHALL be ignored without side effects.

Reset
REQ-019 reset_n low SHALL asynchronously force state IDLE and every output to 0, except start_ready=1.
REQ-020 Reset applies mid-transaction with no done pulse; latched timeout_cycles, max_retries, retries_used and timeout_events are cleared to 0.

Configuration
REQ-021 Macro RESPONSE_TIMEOUT_CONTROLLER_STATS_EN defined: timeout_events increments on each WAIT cycle with timer_expired=1 and abort=0 and response_valid=0, saturating at 16'hFFFF.
REQ-022 With the macro defined, stats_clear=1 SHALL zero timeout_events next cycle and take priority over increment.
REQ-023 Macro undefined: timeout_events SHALL be tied to 0, stats_clear ignored, no counter logic synthesized; ports remain.

Verification
REQ-024 Timeout, no retries: start at T with timeout_cycles=5, max_retries=0 -> done at T+8, done_status=01, retries_used=0, no retry pulse.
REQ-025 Exhausted retries: timeout_cycles=3, max_retries=2 -> retry at T+6 and T+12, done at T+18, status 01, retries_used=2, timeout_events=3 with STATS_EN.
REQ-026 Response: timeout_cycles=5, response_valid at T+4 -> done at T+5, status 00, and response_valid and timer_expired together in WAIT -> status 00.
REQ-027 Abort: abort asserted in WAIT at T+3 -> done at T+4, status 10, and busy low at T+5.
REQ-028 Reset: reset_n low in WAIT -> same-cycle IDLE, start_ready=1, all other outputs 0, and a new start afterwards completes normally.
REQ-029 Saturation (STATS_EN): preload 16'hFFFE, two further expiries -> 16'hFFFF held, and stats_clear -> 0 next cycle.
